lap_timer: RTL and testbench
============================

Name: lap_timer

Overview:
- Times each lap of the player car and produces the binary lap times consumed by the on-screen lap-time text/character stage.
- Sits between the track/collision logic, which reports when the car is on the finish line, and the HUD character generation.
- Free-runs a 10 ms time base from the pixel clock.
- Holds the last completed lap time stable until the next lap completes.

Parameters:
- CLK_FREQ_HZ, 65_000_000, pixel clock frequency.
- TICK_HZ, 100, time-base rate; 1 LSB of every time output = 1/TICK_HZ s. Divider DIV = CLK_FREQ_HZ/TICK_HZ, integer, >= 1.
- MIN_LAP_TICKS, 500, minimum lap time in ticks; finish-line crossings before this are ignored (anti-bounce, anti-reverse-cheat).
- MAX_LAPS, 3, laps per race, range 1..15.

Ports:
- pclk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- race_start  in  1  one-cycle pulse, (re)starts the race.
- line_cross  in  1  level, high while car overlaps finish line, synchronous to pclk.
- current_lap_time  out  16  running time of the lap in progress, in ticks.
- last_lap_time  out  16  time of the most recently completed lap, in ticks.
- best_lap_time  out  16  fastest completed lap, in ticks (see Optional Feature).
- lap_count  out  4  completed laps this race.
- lap_valid  out  1  one-cycle pulse, last_lap_time just updated.
- race_done  out  1  high once MAX_LAPS laps are completed.

Behaviour:
- Reset (async assert, sync release to pclk):
  - all outputs 0, except best_lap_time = 16'hFFFF;
  - FSM = IDLE; prescaler = 0; line_cross edge register = 0.
- Prescaler:
  - counts 0..DIV-1 continuously in all states;
  - tick = 1 on the cycle the count equals DIV-1, then wraps to 0.
- Crossing event: cross_evt = line_cross & ~line_cross_q (rising edge). A held level yields exactly one event.
- FSM states: IDLE, RUNNING, FINISHED.
- race_start, any state:
  - next state RUNNING;
  - prescaler, current_lap_time, lap_count and race_done cleared;
  - last_lap_time and best_lap_time retained;
  - race_start has priority over a coincident cross_evt or tick.
- IDLE: no counting; cross_evt ignored.
- RUNNING, tick: current_lap_time += 1, saturating at 16'hFFFF (no wrap).
- RUNNING, cross_evt with current_lap_time >= MIN_LAP_TICKS (lap accepted):
  - next edge: last_lap_time <= current_lap_time (pre-increment value; a coincident tick is dropped);
  - current_lap_time <= 0;
  - lap_count += 1;
  - lap_valid = 1 for exactly that one cycle;
  - if the new lap_count == MAX_LAPS: state -> FINISHED, race_done = 1.
- RUNNING, cross_evt with current_lap_time < MIN_LAP_TICKS: ignored, no output change.
- FINISHED: current_lap_time held at 0; ticks and cross_evt ignored; outputs held until race_start or reset.
- Latency: line_cross rising at edge N -> last_lap_time/lap_count valid and lap_valid high after edge N+1.
- Reset mid-lap: immediate clear per reset values; no lap_valid is generated.

Optional Feature:
- Macro: LAP_TIMER_BEST_LAP_EN.
- Defined: on each accepted lap, best_lap_time <= min(best_lap_time, lap time), updated on the same edge as last_lap_time. Reset value 16'hFFFF; race_start does not clear it.
- Undefined: best_lap_time is constant 16'hFFFF and no comparator logic is present.

Test Plan:
- Bench parameters: CLK_FREQ_HZ=1000, TICK_HZ=100 (DIV=10), MIN_LAP_TICKS=5, MAX_LAPS=2.
- Reset asserted mid-run, then race_start without crossings for 200 cycles -> during reset all outputs 0, best 16'hFFFF; after start current_lap_time=20, lap_count=0, lap_valid never high.
- race_start, then line_cross high 3 cycles at tick count 12 -> one cycle later last_lap_time=12, lap_count=1, lap_valid high exactly 1 cycle, current_lap_time=0.
- race_start, crossing at current_lap_time=3 -> ignored: lap_count=0, last_lap_time unchanged, current keeps counting.
- Laps of 12 then 8 ticks -> after lap 2: last_lap_time=8, lap_count=2, race_done=1; a further crossing 100 cycles later changes nothing; race_start clears race_done and lap_count but keeps last_lap_time=8.
- With LAP_TIMER_BEST_LAP_EN: laps 8 then 12 -> best_lap_time=8. Without the macro -> best_lap_time=16'hFFFF throughout.
- Saturation, DIV=1 (CLK_FREQ_HZ=TICK_HZ=100): race_start, 70000 cycles without a crossing -> current_lap_time=16'hFFFF; next crossing latches last_lap_time=16'hFFFF.

Source files
------------

// File: rtl/lap_timer.sv
// -----------------------------------------------------------------------------
// lap_timer
//   Times each lap of the player car for the HUD lap-time text stage.
//   A free-running prescaler divides the pixel clock down to a 1/TICK_HZ s
//   time base. The running lap time counts those ticks. A rising edge of
//   line_cross closes the lap once at least MIN_LAP_TICKS have elapsed.
//   The closed lap time is held on last_lap_time until the next lap closes.
//
//   Optional feature (macro LAP_TIMER_BEST_LAP_EN):
//     defined   - best_lap_time tracks the fastest accepted lap.
//     undefined - best_lap_time is tied to 16'hFFFF and has no comparator.
//
// Ports:
//   pclk             in   pixel clock
//   rst_n            in   asynchronous active-low reset
//   race_start       in   one-cycle pulse, (re)starts the race
//   line_cross       in   level, high while the car overlaps the finish line
//   current_lap_time out  ticks elapsed in the lap in progress (saturating)
//   last_lap_time    out  ticks of the most recently completed lap
//   best_lap_time    out  fastest completed lap in ticks, or 16'hFFFF
//   lap_count        out  laps completed in this race
//   lap_valid        out  one-cycle pulse when last_lap_time updates
//   race_done        out  high once MAX_LAPS laps are completed
// -----------------------------------------------------------------------------
module lap_timer #(
  parameter int unsigned CLK_FREQ_HZ   = 65_000_000,
  parameter int unsigned TICK_HZ       = 100,
  parameter int unsigned MIN_LAP_TICKS = 500,
  parameter int unsigned MAX_LAPS      = 3
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        race_start,
  input  logic        line_cross,
  output logic [15:0] current_lap_time,
  output logic [15:0] last_lap_time,
  output logic [15:0] best_lap_time,
  output logic [3:0]  lap_count,
  output logic        lap_valid,
  output logic        race_done
);

  localparam int unsigned  DIV        = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned  PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [15:0]  MIN_LAP    = 16'(MIN_LAP_TICKS);
  localparam logic [3:0]   LAPS       = 4'(MAX_LAPS);

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    FINISHED
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   presc_reg, presc_next;
  logic            line_cross_q;
  logic [15:0]     cur_reg, cur_next;
  logic [15:0]     last_reg, last_next;
  logic [3:0]      lap_count_reg, lap_count_next;
  logic            lap_valid_reg, lap_valid_next;
  logic            race_done_reg, race_done_next;
  logic            tick;
  logic            cross_evt;
  logic [3:0]      lap_count_inc;

  // With DIV == 1 the count stays at 0 and tick is permanently high.
  assign tick          = (presc_reg == PRESC_LAST);
  // A held line_cross level only ever produces one event.
  assign cross_evt     = line_cross & ~line_cross_q;
  assign lap_count_inc = lap_count_reg + 4'd1;

`ifdef LAP_TIMER_BEST_LAP_EN
  logic [15:0] best_reg, best_next;
`endif

  always_comb begin
    state_next     = state_reg;
    presc_next     = tick ? '0 : presc_reg + 1'b1;
    cur_next       = cur_reg;
    last_next      = last_reg;
    lap_count_next = lap_count_reg;
    lap_valid_next = 1'b0;
    race_done_next = race_done_reg;
`ifdef LAP_TIMER_BEST_LAP_EN
    best_next      = best_reg;
`endif

    if (race_start) begin
      // Restart wins over any coincident crossing or tick; lap history stays.
      state_next     = RUNNING;
      presc_next     = '0;
      cur_next       = '0;
      lap_count_next = '0;
      race_done_next = 1'b0;
    end else begin
      case (state_reg)
        RUNNING: begin
          if (cross_evt && (cur_reg >= MIN_LAP)) begin
            // Latch the pre-increment time; a tick landing here is dropped.
            last_next      = cur_reg;
            cur_next       = '0;
            lap_count_next = lap_count_inc;
            lap_valid_next = 1'b1;
`ifdef LAP_TIMER_BEST_LAP_EN
            if (cur_reg < best_reg) begin
              best_next = cur_reg;
            end
`endif
            if (lap_count_inc == LAPS) begin
              state_next     = FINISHED;
              race_done_next = 1'b1;
            end
          end else if (tick && (cur_reg != 16'hFFFF)) begin
            cur_next = cur_reg + 16'd1;
          end
        end
        FINISHED: begin
          cur_next = '0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg     <= '0;
      line_cross_q  <= 1'b0;
      cur_reg       <= '0;
      last_reg      <= '0;
      lap_count_reg <= '0;
      lap_valid_reg <= 1'b0;
      race_done_reg <= 1'b0;
    end else begin
      presc_reg     <= presc_next;
      line_cross_q  <= line_cross;
      cur_reg       <= cur_next;
      last_reg      <= last_next;
      lap_count_reg <= lap_count_next;
      lap_valid_reg <= lap_valid_next;
      race_done_reg <= race_done_next;
    end
  end

`ifdef LAP_TIMER_BEST_LAP_EN
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      best_reg <= 16'hFFFF;
    end else begin
      best_reg <= best_next;
    end
  end

  assign best_lap_time = best_reg;
`else
  assign best_lap_time = 16'hFFFF;
`endif

  assign current_lap_time = cur_reg;
  assign last_lap_time    = last_reg;
  assign lap_count        = lap_count_reg;
  assign lap_valid        = lap_valid_reg;
  assign race_done        = race_done_reg;

endmodule

// File: tb/tb_lap_timer.sv
`timescale 1ns/1ps
module tb_lap_timer;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        race_start = 1'b0;
  logic        line_cross = 1'b0;
  logic        s_race_start = 1'b0;
  logic        s_line_cross = 1'b0;

  logic [15:0] current_lap_time, last_lap_time, best_lap_time;
  logic [3:0]  lap_count;
  logic        lap_valid, race_done;

  logic [15:0] s_current_lap_time, s_last_lap_time, s_best_lap_time;
  logic [3:0]  s_lap_count;
  logic        s_lap_valid, s_race_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sat_e0 = 0;
  int vcount;

`ifdef LAP_TIMER_BEST_LAP_EN
  localparam logic [15:0] BEST_AFTER_8 = 16'd8;
`else
  localparam logic [15:0] BEST_AFTER_8 = 16'hFFFF;
`endif

  // Main DUT: DIV = 10, min lap 5 ticks, 2-lap race.
  lap_timer #(
    .CLK_FREQ_HZ(1000), .TICK_HZ(100), .MIN_LAP_TICKS(5), .MAX_LAPS(2)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .race_start(race_start), .line_cross(line_cross),
    .current_lap_time(current_lap_time), .last_lap_time(last_lap_time),
    .best_lap_time(best_lap_time), .lap_count(lap_count),
    .lap_valid(lap_valid), .race_done(race_done)
  );

  // Saturation DUT: DIV = 1, ticks every cycle.
  lap_timer #(
    .CLK_FREQ_HZ(100), .TICK_HZ(100), .MIN_LAP_TICKS(5), .MAX_LAPS(2)
  ) dut_sat (
    .pclk(pclk), .rst_n(s_rst_n), .race_start(s_race_start), .line_cross(s_line_cross),
    .current_lap_time(s_current_lap_time), .last_lap_time(s_last_lap_time),
    .best_lap_time(s_best_lap_time), .lap_count(s_lap_count),
    .lap_valid(s_lap_valid), .race_done(s_race_done)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic start_race();
    race_start = 1'b1;
    step(1);
    race_start = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_cur"},   current_lap_time, 16'd0);
    check({pfx, "_last"},  last_lap_time, 16'd0);
    check({pfx, "_best"},  best_lap_time, 16'hFFFF);
    check({pfx, "_count"}, 16'(lap_count), 16'd0);
    check({pfx, "_valid"}, 16'(lap_valid), 16'd0);
    check({pfx, "_done"},  16'(race_done), 16'd0);
  endtask

  initial begin
    // Power-on reset
    step(2);
    check_reset_vals("por");
    rst_n = 1'b1;
    s_rst_n = 1'b1;
    step(1);

    // Kick off the saturation DUT; it runs alongside everything else.
    s_race_start = 1'b1;
    step(1);
    s_race_start = 1'b0;
    sat_e0 = cyc;

    // Reset asserted mid-lap (current = 3 at that point)
    start_race();
    step(37);
    check("pre_rst_cur", current_lap_time, 16'd3);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    step(2);
    rst_n = 1'b1;
    step(1);

    // No crossings for 200 cycles -> 20 ticks, no lap_valid
    start_race();
    vcount = 0;
    repeat (200) begin
      step(1);
      if (lap_valid) vcount++;
    end
    check("run200_cur", current_lap_time, 16'd20);
    check("run200_count", 16'(lap_count), 16'd0);
    check("run200_valid_seen", 16'(vcount), 16'd0);

    // Lap of 12 ticks, line held 3 cycles
    start_race();
    step(120);
    check("lap12_pre_cur", current_lap_time, 16'd12);
    line_cross = 1'b1;
    step(1);
    check("lap12_last", last_lap_time, 16'd12);
    check("lap12_count", 16'(lap_count), 16'd1);
    check("lap12_valid", 16'(lap_valid), 16'd1);
    check("lap12_cur", current_lap_time, 16'd0);
    step(1);
    check("lap12_valid_drop", 16'(lap_valid), 16'd0);
    step(1);
    line_cross = 1'b0;
    check("lap12_held_count", 16'(lap_count), 16'd1);
    check("lap12_best", best_lap_time, (BEST_AFTER_8 == 16'hFFFF) ? 16'hFFFF : 16'd12);

    // Too-early crossing at 3 ticks is ignored
    start_race();
    step(30);
    check("early_pre_cur", current_lap_time, 16'd3);
    line_cross = 1'b1;
    step(1);
    line_cross = 1'b0;
    check("early_count", 16'(lap_count), 16'd0);
    check("early_valid", 16'(lap_valid), 16'd0);
    check("early_last", last_lap_time, 16'd12);
    step(9);
    check("early_cur_keeps", current_lap_time, 16'd4);

    // Laps of 12 then 8 ticks -> race done
    start_race();
    step(120);
    line_cross = 1'b1;
    step(1);
    check("r2_lap1_last", last_lap_time, 16'd12);
    check("r2_lap1_count", 16'(lap_count), 16'd1);
    step(2);
    line_cross = 1'b0;
    step(77);
    check("r2_lap2_pre_cur", current_lap_time, 16'd8);
    line_cross = 1'b1;
    step(1);
    line_cross = 1'b0;
    check("r2_lap2_last", last_lap_time, 16'd8);
    check("r2_lap2_count", 16'(lap_count), 16'd2);
    check("r2_done", 16'(race_done), 16'd1);
    check("r2_lap2_valid", 16'(lap_valid), 16'd1);
    check("r2_lap2_cur", current_lap_time, 16'd0);
    step(100);
    check("fin_cur_held", current_lap_time, 16'd0);
    line_cross = 1'b1;
    step(1);
    line_cross = 1'b0;
    check("fin_last", last_lap_time, 16'd8);
    check("fin_count", 16'(lap_count), 16'd2);
    check("fin_done", 16'(race_done), 16'd1);
    check("fin_valid", 16'(lap_valid), 16'd0);
    start_race();
    check("restart_done", 16'(race_done), 16'd0);
    check("restart_count", 16'(lap_count), 16'd0);
    check("restart_last", last_lap_time, 16'd8);
    check("restart_cur", current_lap_time, 16'd0);

    // Fresh reset, laps of 8 then 12 -> best stays 8 (if enabled)
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    start_race();
    step(80);
    line_cross = 1'b1;
    step(1);
    line_cross = 1'b0;
    check("b_lap1_last", last_lap_time, 16'd8);
    check("b_lap1_best", best_lap_time, BEST_AFTER_8);
    step(119);
    check("b_lap2_pre_cur", current_lap_time, 16'd12);
    line_cross = 1'b1;
    step(1);
    line_cross = 1'b0;
    check("b_lap2_last", last_lap_time, 16'd12);
    check("b_lap2_best", best_lap_time, BEST_AFTER_8);
    check("b_done", 16'(race_done), 16'd1);

    // Saturation: 70000 ticks since the DIV=1 race started
    if (cyc - sat_e0 < 70000) step(70000 - (cyc - sat_e0));
    check("sat_cur", s_current_lap_time, 16'hFFFF);
    check("sat_count_pre", 16'(s_lap_count), 16'd0);
    s_line_cross = 1'b1;
    step(1);
    s_line_cross = 1'b0;
    check("sat_last", s_last_lap_time, 16'hFFFF);
    check("sat_valid", 16'(s_lap_valid), 16'd1);
    check("sat_count", 16'(s_lap_count), 16'd1);
    check("sat_cur_after", s_current_lap_time, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
